// File: rtl/axi_lite_arbiter.sv
// 2:1 AXI4-lite arbiter: IFU (read-only) and LSU (read/write) share one slave port.
// Optional ARB_RR_EN: round-robin read arbitration (LSU write keeps absolute priority).
module axi_lite_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // IFU read
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  input  logic [2:0]            ifu_arsize,
  output logic                  ifu_arready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  input  logic [2:0]            lsu_arsize,
  output logic                  lsu_arready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // LSU write
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  output logic                  lsu_awready,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  // Shared slave port
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  output logic [2:0]            m_arsize,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [1:0]            grant
);

  // Encodings double as the grant output value.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StIfuR = 2'b01,
    StLsuR = 2'b10,
    StLsuW = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   rd_tie_ifu;

`ifdef ARB_RR_EN
  // 0: IFU granted last, 1: LSU granted last.
  logic last_rd_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rd_grant_q <= 1'b0;
    end else if (state_q == StIdle && state_d == StIfuR) begin
      last_rd_grant_q <= 1'b0;
    end else if (state_q == StIdle && state_d == StLsuR) begin
      last_rd_grant_q <= 1'b1;
    end
  end

  assign rd_tie_ifu = last_rd_grant_q;
`else
  assign rd_tie_ifu = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (lsu_awvalid || lsu_wvalid) begin
          state_d = StLsuW;
        end else if (lsu_arvalid && ifu_arvalid) begin
          state_d = rd_tie_ifu ? StIfuR : StLsuR;
        end else if (lsu_arvalid) begin
          state_d = StLsuR;
        end else if (ifu_arvalid) begin
          state_d = StIfuR;
        end
      end
      StIfuR, StLsuR: if (m_rvalid && m_rready) state_d = StIdle;
      StLsuW:         if (m_bvalid && m_bready) state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  assign grant = state_q;

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_arsize    = '0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    case (state_q)
      StIfuR: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid;
        m_arsize    = ifu_arsize;
        ifu_arready = m_arready;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
      end
      StLsuR: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid;
        m_arsize    = lsu_arsize;
        lsu_arready = m_arready;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
      end
      StLsuW: begin
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid;
        lsu_awready = m_awready;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid;
        lsu_wready  = m_wready;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid;
        m_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter (default fixed-priority build).
module tb_axi_lite_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, m_rdata;
  logic [31:0] ifu_rdata, lsu_rdata, m_araddr, m_awaddr, m_wdata;
  logic [2:0]  ifu_arsize, lsu_arsize, m_arsize;
  logic [3:0]  lsu_wstrb, m_wstrb;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, m_rresp, m_bresp, grant;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic        m_wvalid, m_wready, m_bvalid, m_bready;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arsize(ifu_arsize),
    .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arsize(lsu_arsize),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arsize(m_arsize), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    ifu_araddr = '0; ifu_arvalid = 0; ifu_arsize = 3'd2; ifu_rready = 1;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_arsize = 3'd2; lsu_rready = 1;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0;
    lsu_bready = 1;
    m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;

    // Reset state
    tick(); settle();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_m_arvalid", 32'(m_arvalid), 32'h0);
    check("rst_m_rready", 32'(m_rready), 32'h0);
    check("rst_m_bready", 32'(m_bready), 32'h0);
    tick(); rst = 1'b0;

    // IFU read alone
    tick(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; settle();
    check("ifu1_grant_pre", 32'(grant), 32'h0);
    check("ifu1_m_arvalid_pre", 32'(m_arvalid), 32'h0);
    tick(); m_arready = 1; settle();
    check("ifu1_grant", 32'(grant), 32'h1);
    check("ifu1_m_araddr", m_araddr, 32'h8000_0000);
    check("ifu1_m_arsize", 32'(m_arsize), 32'h2);
    check("ifu1_arready", 32'(ifu_arready), 32'h1);
    tick(); ifu_arvalid = 0; m_arready = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("ifu1_rvalid_wait", 32'(ifu_rvalid), 32'h0);
      tick();
    end
    m_rvalid = 1; m_rdata = 32'h0000_0413; m_rresp = 2'b00; settle();
    check("ifu1_rvalid", 32'(ifu_rvalid), 32'h1);
    check("ifu1_rdata", ifu_rdata, 32'h0000_0413);
    check("ifu1_rresp", 32'(ifu_rresp), 32'h0);
    check("ifu1_m_rready", 32'(m_rready), 32'h1);
    check("ifu1_lsu_rvalid", 32'(lsu_rvalid), 32'h0);
    tick(); m_rvalid = 0; settle();
    check("ifu1_grant_done", 32'(grant), 32'h0);

    // Simultaneous IFU/LSU read: LSU first
    tick();
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0100;
    tick(); m_arready = 1; settle();
    check("rd2_grant_lsu", 32'(grant), 32'h2);
    check("rd2_lsu_arready", 32'(lsu_arready), 32'h1);
    check("rd2_ifu_arready", 32'(ifu_arready), 32'h0);
    tick(); lsu_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h1111_1111; settle();
    check("rd2_lsu_rdata", lsu_rdata, 32'h1111_1111);
    check("rd2_ifu_rvalid", 32'(ifu_rvalid), 32'h0);
    tick(); m_rvalid = 0; settle();
    check("rd2_idle_gap", 32'(grant), 32'h0);
    tick(); m_arready = 1; settle();
    check("rd2_grant_ifu", 32'(grant), 32'h1);
    check("rd2_ifu_arready2", 32'(ifu_arready), 32'h1);
    tick(); ifu_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h2222_2222; settle();
    check("rd2_ifu_rdata", ifu_rdata, 32'h2222_2222);
    tick(); m_rvalid = 0; settle();
    check("rd2_grant_done", 32'(grant), 32'h0);

    // LSU write with concurrent IFU read; awready before wready, error bresp
    tick();
    lsu_awvalid = 1; lsu_awaddr = 32'ha000_03f8;
    lsu_wvalid = 1; lsu_wdata = 32'h41; lsu_wstrb = 4'b0001;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0200;
    tick(); m_awready = 1; m_wready = 0; m_arready = 1; settle();
    check("wr_grant", 32'(grant), 32'h3);
    check("wr_m_awaddr", m_awaddr, 32'ha000_03f8);
    check("wr_m_wdata", m_wdata, 32'h41);
    check("wr_m_wstrb", 32'(m_wstrb), 32'h1);
    check("wr_awready", 32'(lsu_awready), 32'h1);
    check("wr_wready_early", 32'(lsu_wready), 32'h0);
    check("wr_ifu_arready", 32'(ifu_arready), 32'h0);
    check("wr_m_arvalid", 32'(m_arvalid), 32'h0);
    tick(); lsu_awvalid = 0; m_awready = 0; m_wready = 1; settle();
    check("wr_wready", 32'(lsu_wready), 32'h1);
    check("wr_m_awvalid_off", 32'(m_awvalid), 32'h0);
    tick(); lsu_wvalid = 0; m_wready = 0; settle();
    check("wr_grant_hold", 32'(grant), 32'h3);
    tick(); m_bvalid = 1; m_bresp = 2'b10; settle();
    check("wr_bvalid", 32'(lsu_bvalid), 32'h1);
    check("wr_bresp", 32'(lsu_bresp), 32'h2);
    check("wr_m_bready", 32'(m_bready), 32'h1);
    tick(); m_bvalid = 0; m_bresp = 2'b00; settle();
    check("wr_grant_done", 32'(grant), 32'h0);
    check("wr_ifu_arready_idle", 32'(ifu_arready), 32'h0);

    // IFU granted next; slave stalls rvalid 20 cycles while LSU requests
    tick(); settle();
    check("stall_grant_ifu", 32'(grant), 32'h1);
    check("stall_ifu_arready", 32'(ifu_arready), 32'h1);
    tick(); ifu_arvalid = 0; m_arready = 1; lsu_arvalid = 1; lsu_araddr = 32'h8000_0300;
    for (int i = 0; i < 20; i++) begin
      settle();
      check("stall_grant", 32'(grant), 32'h1);
      check("stall_lsu_arready", 32'(lsu_arready), 32'h0);
      tick();
    end
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h3333_3333; settle();
    check("stall_ifu_rdata", ifu_rdata, 32'h3333_3333);
    tick(); m_rvalid = 0; settle();
    check("stall_idle", 32'(grant), 32'h0);
    tick(); m_arready = 1; settle();
    check("stall_grant_lsu", 32'(grant), 32'h2);
    check("stall_lsu_arready2", 32'(lsu_arready), 32'h1);
    tick(); lsu_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h4444_4444;
    tick(); m_rvalid = 0; settle();
    check("stall_lsu_done", 32'(grant), 32'h0);

    // Reset during G_LSU_W before bvalid
    tick(); lsu_awvalid = 1; lsu_awaddr = 32'ha000_0000; lsu_wvalid = 1; lsu_wdata = 32'h55;
    tick(); settle();
    check("rstw_grant", 32'(grant), 32'h3);
    check("rstw_m_awvalid", 32'(m_awvalid), 32'h1);
    rst = 1'b1; settle();
    check("rstw_grant_rst", 32'(grant), 32'h0);
    check("rstw_m_awvalid_rst", 32'(m_awvalid), 32'h0);
    check("rstw_m_wvalid_rst", 32'(m_wvalid), 32'h0);
    check("rstw_m_bready_rst", 32'(m_bready), 32'h0);
    check("rstw_m_awaddr_rst", m_awaddr, 32'h0);
    lsu_awvalid = 0; lsu_wvalid = 0;
    tick(); rst = 1'b0;
    tick(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0400;
    tick(); m_arready = 1; settle();
    check("post_grant", 32'(grant), 32'h1);
    check("post_arready", 32'(ifu_arready), 32'h1);
    tick(); ifu_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h5555_5555; settle();
    check("post_rdata", ifu_rdata, 32'h5555_5555);
    tick(); m_rvalid = 0; settle();
    check("post_done", 32'(grant), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
